// File: rtl/sync_bus_master_if.sv
// Requester handshake and shared-bus control signals of sync_bus_master.
// The bidirectional data bus is kept as a plain inout net on the master itself.
interface sync_bus_master_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rd;
  logic              bus_wr;
  logic              bus_rdy;

  modport master (
    input  req, we, addr, wdata, bus_rdy,
    output busy, done, err, rdata, bus_addr, bus_rd, bus_wr
  );

  modport slave (
    output req, we, addr, wdata, bus_rdy,
    input  busy, done, err, rdata, bus_addr, bus_rd, bus_wr
  );
endinterface

// File: rtl/sync_bus_master.sv
// Single-word bus master: turns a requester's read/write into a strobed bus cycle
// with device wait states and a timeout abort. All outputs are registered.
module sync_bus_master #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 reset_n,
  sync_bus_master_if.master    bif,
  inout  wire  [DATA_W-1:0]    bus_data
);

  localparam int unsigned          CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bif.req) begin
          we_d    = bif.we;
          wdata_d = bif.wdata;
          addr_d  = bif.addr;
          rd_d    = !bif.we;
          wr_d    = bif.we;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Ready wins over timeout when both happen on the same edge.
        if (bif.bus_rdy || (cnt_q == CNT_LAST)) begin
          if (bif.bus_rdy && !we_q) rdata_d = bus_data;
          addr_d  = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = !bif.bus_rdy;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bif.busy     = busy_q;
  assign bif.done     = done_q;
  assign bif.err      = err_q;
  assign bif.rdata    = rdata_q;
  assign bif.bus_addr = addr_q;
  assign bif.bus_rd   = rd_q;
  assign bif.bus_wr   = wr_q;

  // The write strobe and the data driver share one register, so they switch together.
  assign bus_data = wr_q ? wdata_q : 'z;

endmodule

// File: doc/sync_bus_master.md
# sync_bus_master

Synchronous bus master controller that turns single-word read/write requests from a local requester into transactions on the shared address/data bus. It sits directly upstream of the bus devices: it drives the address bus and the read/write strobes, drives the bidirectional data bus for writes, and captures device data on reads. Devices may insert wait states with `bus_rdy`. A timeout ends transactions to absent devices with an error.

## Interface
Parameters:
- `ADDR_W`, 8: address bus width.
- `DATA_W`, 8: data bus width.
- `TIMEOUT`, 15: WAIT edges without `bus_rdy` before abort; legal range ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  bus clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `req`  in  1  transaction request, sampled in IDLE.
- `we`  in  1  1 = write, 0 = read; captured with `req`.
- `addr`  in  ADDR_W  target address; captured with `req`.
- `wdata`  in  DATA_W  write data; captured with `req`.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; 1 = timeout.
- `rdata`  out  DATA_W  read result; holds until the next successful read.
- `bus_addr`  out  ADDR_W  address bus; 0 when idle.
- `bus_rd`  out  1  read strobe.
- `bus_wr`  out  1  write strobe.
- `bus_data`  inout  DATA_W  data bus; driven only while `bus_wr`=1, else Z.
- `bus_rdy`  in  1  device ready / data valid.

## Operation
- States: IDLE, WAIT. Registered outputs only; no combinational path from inputs to outputs.
- IDLE, `req`=1 at an edge (accept edge):
  - Latch `we`, `addr`, `wdata`.
  - `bus_addr`←addr.
  - `bus_rd`←!we, `bus_wr`←we.
  - Set `busy`=1 and clear the wait counter.
  - Go to WAIT.
- IDLE, `req`=0: outputs hold idle values. `done`/`err` clear to 0.
- WAIT, at each edge:
  - `bus_rdy`=1 (success): on a read, `rdata`←`bus_data`. Drop the strobes, set `bus_addr`←0, release `bus_data`. Pulse `done`=1, `err`=0, `busy`=0. Go to IDLE.
  - Else, counter = TIMEOUT−1 (timeout): same bus release. Pulse `done`=1, `err`=1, `busy`=0. `rdata` unchanged. Go to IDLE.
  - Else: counter+1, bus signals held.
- `bus_rdy` has priority over timeout on the same edge.
- Requester inputs are ignored while `busy`=1. Changes to `addr`/`wdata`/`we` mid-transaction have no effect.
- Counter width: $clog2(TIMEOUT+1). The counter never wraps.
- `bus_data` is driven continuously with the latched `wdata` from the accept edge to the completion edge. It is never driven during reads.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE.
  - `bus_addr`=0, `bus_rd`=0, `bus_wr`=0, `bus_data`=Z.
  - `rdata`=0, `done`=0, `err`=0, `busy`=0, counter=0.
- Reset asserted mid-transaction abandons it with no `done` pulse. The first edge after deassertion can accept a new `req`.
- Edges are numbered from the accept edge E0; WAIT edges are E1, E2, …
- Zero-wait device (`bus_rdy` high during the first WAIT cycle): completion at E1. `done` is visible E1→E2.
- N wait states: completion at E(N+1). Strobe high for N+1 cycles.
- Timeout: `bus_rdy` never seen, so `done`+`err` at E(TIMEOUT). A `bus_rdy` sampled at E(TIMEOUT) is a success.
- Back-to-back: `req` held high gives an accept at the edge after completion. Maximum throughput is one transaction per 2 cycles.
- `done` is never high for two consecutive cycles.

## Test plan
- Zero-wait read: req, we=0, addr=F0; device drives E3 with `bus_rdy` immediately. Required: `bus_rd` high 1 cycle; at E1 `done`=1, `err`=0, `rdata`=E3; `bus_addr` returns to 00 and `bus_data`=Z.
- Write with 3 wait states: addr=10, wdata=5A; `bus_rdy` first sampled high at E4. Required: `bus_wr`=1 and `bus_data`=5A over E0–E4; `done` at E4 with `err`=0; `rdata` unchanged.
- Timeout: read addr=22 with no device, TIMEOUT=15. Required: `done`=1 and `err`=1 at E15; `rdata` keeps its prior value; bus idle afterwards.
- Boundary: with TIMEOUT=15, `bus_rdy` first sampled high at E15. Required: success with `err`=0 and `rdata` captured. Repeat with TIMEOUT=1: no `bus_rdy` gives `err` at E1.
- Stream and ignore: `req` held high while `addr` changes every cycle. Required: accepts every 2 cycles; each transaction uses the address present at its accept edge; `busy` matches.
- Reset mid-WAIT: assert `reset_n`=0 at E2 of a write. Required: immediate reset values with `bus_data`=Z and no `done`. After release, a read of F0 completes normally with E3.
